// File: rtl/serial_sub_pkg.sv
// Shared encodings for the bit-serial subtractor.
// Default width and FSM state encoding; no logic.
package serial_sub_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: Diff = A - B - Bin, Bout = borrow out.
// Purely combinational, no backpressure.
module full_sub (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);
  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~A & Bin) | (B & Bin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin, LSB first, through one full_sub cell; SERIAL_SUB_OVF_EN adds ovf.
// Latency: result registered WIDTH edges after start is accepted, done pulses one cycle.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             borrow_q, borrow_d;
  logic             fs_diff, fs_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  full_sub u_full_sub (
    .A   (a_sh_q[0]),
    .B   (b_sh_q[0]),
    .Bin (brw_q),
    .Diff(fs_diff),
    .Bout(fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        // Result bits fill a_sh from the top as minuend bits leave the bottom.
        a_sh_d = {fs_diff, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        brw_d  = fs_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          diff_d   = {fs_diff, a_sh_q[WIDTH-1:1]};
          borrow_d = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (a_msb_q != b_msb_q) && (fs_diff != a_msb_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl (WIDTH=8); ovf checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_ctrl;
  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    int           at;
  } exp_t;

  exp_t exp_q[$];

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Golden result from plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input int at);
    exp_t e;
    int   r;
    r    = int'(x) - int'(y) - int'(c);
    e.d  = r[W-1:0];
    e.br = (r < 0);
    e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
    e.at = at;
    return e;
  endfunction

  exp_t got;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: done=1 with nothing pending (cycle %0d)", cyc);
      end else begin
        got = exp_q.pop_front();
        check("diff", 32'(diff), 32'(got.d));
        check("borrow_out", 32'(borrow_out), 32'(got.br));
        check("done_cycle", cyc, got.at);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(got.ov));
`endif
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    wait_idle();
    a     = x;
    b     = y;
    bin   = c;
    start = 1'b1;
    exp_q.push_back(model(x, y, c, cyc + 1 + W));
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    check("busy_run", 32'(busy), 32'd1);
    check("done_run", 32'(done), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    do_op(8'h05, 8'h03, 1'b0);
    do_op(8'h03, 8'h05, 1'b0);
    do_op(8'h00, 8'h00, 1'b1);
    do_op(8'h80, 8'h01, 1'b0);
    do_op(8'h7F, 8'hFF, 1'b0);
    do_op(8'h3C, 8'h3C, 1'b0);

    // Start pulse with fresh operands mid-run must be dropped.
    do_op(8'h09, 8'h04, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a     = 8'hAA;
    b     = 8'h11;
    bin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignored_start", 32'(busy), 32'd1);

    // Reset four edges into a run: aborted, no done, outputs cleared.
    do_op(8'h55, 8'h11, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h20, 8'h01, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom));
    end

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("pending", exp_q.size(), 32'd0);
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
